// File: rtl/reg_read.sv
`default_nettype none
// reg_read -- operand-read arbiter: maps up to three sources onto two synchronous
// register-file read ports and forwards in-window writebacks. Rev 1.0
module reg_read #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_rs_en1,
  input  logic          i_rs_en2,
  input  logic          i_rs_en3,
  input  logic [AW-1:0] i_rs_add1,
  input  logic [AW-1:0] i_rs_add2,
  input  logic [AW-1:0] i_rs_add3,
  output logic          o_rf_ren1,
  output logic          o_rf_ren2,
  output logic [AW-1:0] o_rf_radd1,
  output logic [AW-1:0] o_rf_radd2,
  input  logic [DW-1:0] i_rf_rdata1,
  input  logic [DW-1:0] i_rf_rdata2,
  input  logic          i_wrd_en1,
  input  logic          i_wrd_en2,
  input  logic [AW-1:0] i_wrd_add1,
  input  logic [AW-1:0] i_wrd_add2,
  input  logic [DW-1:0] i_wrd_data1,
  input  logic [DW-1:0] i_wrd_data2,
  output logic          o_op_valid,
  output logic [DW-1:0] o_op_data1,
  output logic [DW-1:0] o_op_data2,
  output logic [DW-1:0] o_op_data3,
  output logic          o_oc_pause
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_PASS2    = 2'd2,
    ST_CAPTURE3 = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          w_accept;
  logic          w_pass2;
  logic          w_n3;
  logic [1:0]    w_p1_src;
  logic [1:0]    w_p2_src;
  logic [AW-1:0] w_p1_add;
  logic [AW-1:0] w_p2_add;

  logic [1:0]    r_slot1;
  logic [1:0]    r_slot2;
  logic [AW-1:0] r_add3;
  logic [AW-1:0] r_cap_add1;
  logic [AW-1:0] r_cap_add2;
  logic          r_ifw_hit1;
  logic          r_ifw_hit2;
  logic [DW-1:0] r_ifw_data1;
  logic [DW-1:0] r_ifw_data2;
  logic [DW-1:0] r_hold1;
  logic [DW-1:0] r_hold2;
  logic          r_op_valid;
  logic [DW-1:0] r_op_data1;
  logic [DW-1:0] r_op_data2;
  logic [DW-1:0] r_op_data3;
  logic [DW-1:0] w_fwd1;
  logic [DW-1:0] w_fwd2;

  function automatic logic [DW-1:0] f_pick(
    input logic [1:0]    slot1,
    input logic [1:0]    slot2,
    input logic [DW-1:0] fwd1,
    input logic [DW-1:0] fwd2,
    input logic [1:0]    src
  );
    if (slot1 == src)      return fwd1;
    else if (slot2 == src) return fwd2;
    else                   return '0;
  endfunction

  // Lowest-numbered enabled source on port 1, the next one on port 2.
  always_comb begin
    w_p1_src = 2'd0;
    w_p2_src = 2'd0;
    w_p1_add = '0;
    w_p2_add = '0;
    if (i_rs_en1) begin
      w_p1_src = 2'd1;
      w_p1_add = i_rs_add1;
      if (i_rs_en2) begin
        w_p2_src = 2'd2;
        w_p2_add = i_rs_add2;
      end else if (i_rs_en3) begin
        w_p2_src = 2'd3;
        w_p2_add = i_rs_add3;
      end
    end else if (i_rs_en2) begin
      w_p1_src = 2'd2;
      w_p1_add = i_rs_add2;
      if (i_rs_en3) begin
        w_p2_src = 2'd3;
        w_p2_add = i_rs_add3;
      end
    end else if (i_rs_en3) begin
      w_p1_src = 2'd3;
      w_p1_add = i_rs_add3;
    end
  end

  assign w_n3 = i_rs_en1 & i_rs_en2 & i_rs_en3;

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_pass2     = (r_state == ST_PASS2) && !reset;
    o_req_ready = !reset && (r_state != ST_PASS2);
    o_oc_pause  = w_pass2;
    w_accept    = i_req_valid && o_req_ready;
    o_rf_ren1   = 1'b0;
    o_rf_ren2   = 1'b0;
    o_rf_radd1  = '0;
    o_rf_radd2  = '0;
    if (r_state == ST_PASS2) begin
      w_state_nxt = ST_CAPTURE3;
    end else if (w_accept) begin
      w_state_nxt = w_n3 ? ST_PASS2 : ST_CAPTURE;
    end
    if (w_pass2) begin
      o_rf_ren1  = 1'b1;
      o_rf_radd1 = r_add3;
    end else if (w_accept) begin
      o_rf_ren1  = (w_p1_src != 2'd0);
      o_rf_ren2  = (w_p2_src != 2'd0);
      o_rf_radd1 = w_p1_add;
      o_rf_radd2 = w_p2_add;
    end
  end

  // Capture-cycle writes beat the writes registered from the issue cycle.
  always_comb begin
    w_fwd1 = i_rf_rdata1;
    w_fwd2 = i_rf_rdata2;
    if (i_wrd_en2 && (i_wrd_add2 == r_cap_add1))      w_fwd1 = i_wrd_data2;
    else if (i_wrd_en1 && (i_wrd_add1 == r_cap_add1)) w_fwd1 = i_wrd_data1;
    else if (r_ifw_hit1)                              w_fwd1 = r_ifw_data1;
    if (i_wrd_en2 && (i_wrd_add2 == r_cap_add2))      w_fwd2 = i_wrd_data2;
    else if (i_wrd_en1 && (i_wrd_add1 == r_cap_add2)) w_fwd2 = i_wrd_data1;
    else if (r_ifw_hit2)                              w_fwd2 = r_ifw_data2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_slot1     <= 2'd0;
      r_slot2     <= 2'd0;
      r_add3      <= '0;
      r_cap_add1  <= '0;
      r_cap_add2  <= '0;
      r_ifw_hit1  <= 1'b0;
      r_ifw_hit2  <= 1'b0;
      r_ifw_data1 <= '0;
      r_ifw_data2 <= '0;
      r_hold1     <= '0;
      r_hold2     <= '0;
      r_op_valid  <= 1'b0;
      r_op_data1  <= '0;
      r_op_data2  <= '0;
      r_op_data3  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_slot1 <= w_p1_src;
        r_slot2 <= w_p2_src;
        r_add3  <= i_rs_add3;
      end
      r_cap_add1  <= o_rf_radd1;
      r_cap_add2  <= o_rf_radd2;
      r_ifw_hit1  <= (i_wrd_en1 && (i_wrd_add1 == o_rf_radd1)) ||
                     (i_wrd_en2 && (i_wrd_add2 == o_rf_radd1));
      r_ifw_hit2  <= (i_wrd_en1 && (i_wrd_add1 == o_rf_radd2)) ||
                     (i_wrd_en2 && (i_wrd_add2 == o_rf_radd2));
      r_ifw_data1 <= (i_wrd_en2 && (i_wrd_add2 == o_rf_radd1)) ? i_wrd_data2 : i_wrd_data1;
      r_ifw_data2 <= (i_wrd_en2 && (i_wrd_add2 == o_rf_radd2)) ? i_wrd_data2 : i_wrd_data1;
      r_op_valid  <= (r_state == ST_CAPTURE) || (r_state == ST_CAPTURE3);
      case (r_state)
        ST_CAPTURE: begin
          r_op_data1 <= f_pick(r_slot1, r_slot2, w_fwd1, w_fwd2, 2'd1);
          r_op_data2 <= f_pick(r_slot1, r_slot2, w_fwd1, w_fwd2, 2'd2);
          r_op_data3 <= f_pick(r_slot1, r_slot2, w_fwd1, w_fwd2, 2'd3);
        end
        ST_PASS2: begin
          r_hold1 <= w_fwd1;
          r_hold2 <= w_fwd2;
        end
        ST_CAPTURE3: begin
          r_op_data1 <= r_hold1;
          r_op_data2 <= r_hold2;
          r_op_data3 <= w_fwd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_op_valid = r_op_valid;
  assign o_op_data1 = r_op_data1;
  assign o_op_data2 = r_op_data2;
  assign o_op_data3 = r_op_data3;

endmodule
`default_nettype wire

// File: tb/tb_reg_read.sv
`default_nettype none
// tb_reg_read -- directed + randomized bench for reg_read; operands are predicted as the
// register value after all writes through the capture cycle. Rev 1.0
module tb_reg_read;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic          rs_en1, rs_en2, rs_en3;
  logic [AW-1:0] rs_add1, rs_add2, rs_add3;
  logic          rf_ren1, rf_ren2;
  logic [AW-1:0] rf_radd1, rf_radd2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic          wrd_en1, wrd_en2;
  logic [AW-1:0] wrd_add1, wrd_add2;
  logic [DW-1:0] wrd_data1, wrd_data2;
  logic          op_valid, oc_pause;
  logic [DW-1:0] op_data1, op_data2, op_data3;

  always #5 clk = ~clk;

  reg_read #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_rs_en1(rs_en1), .i_rs_en2(rs_en2), .i_rs_en3(rs_en3),
    .i_rs_add1(rs_add1), .i_rs_add2(rs_add2), .i_rs_add3(rs_add3),
    .o_rf_ren1(rf_ren1), .o_rf_ren2(rf_ren2),
    .o_rf_radd1(rf_radd1), .o_rf_radd2(rf_radd2),
    .i_rf_rdata1(rf_rdata1), .i_rf_rdata2(rf_rdata2),
    .i_wrd_en1(wrd_en1), .i_wrd_en2(wrd_en2),
    .i_wrd_add1(wrd_add1), .i_wrd_add2(wrd_add2),
    .i_wrd_data1(wrd_data1), .i_wrd_data2(wrd_data2),
    .o_op_valid(op_valid),
    .o_op_data1(op_data1), .o_op_data2(op_data2), .o_op_data3(op_data3),
    .o_oc_pause(oc_pause)
  );

  typedef struct {
    int            due;
    int            cap12;
    int            cap3;
    logic [2:0]    en;
    logic [AW-1:0] a1, a2, a3;
    logic [DW-1:0] v1, v2, v3;
  } op_t;

  logic [DW-1:0] mem [0:127];
  op_t           q[$];
  int            cyc, n_cmp, n_err;
  logic          pass2_exp;
  logic [AW-1:0] pass2_add;
  logic [DW-1:0] hold1, hold2, hold3;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input logic [2:0] en, input int a1, input int a2, input int a3);
    req_valid = 1'b1;
    {rs_en3, rs_en2, rs_en1} = en;
    rs_add1 = AW'(a1);
    rs_add2 = AW'(a2);
    rs_add3 = AW'(a3);
  endtask

  task automatic set_wr(input logic e1, input int a1, input logic [DW-1:0] d1,
                        input logic e2, input int a2, input logic [DW-1:0] d2);
    wrd_en1 = e1; wrd_add1 = AW'(a1); wrd_data1 = d1;
    wrd_en2 = e2; wrd_add2 = AW'(a2); wrd_data2 = d2;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    {rs_en3, rs_en2, rs_en1} = 3'b000;
    set_wr(1'b0, 0, '0, 1'b0, 0, '0);
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic cycle();
    logic          exp_ready, exp_ren1, exp_ren2, acc, p2_next, ov;
    logic [AW-1:0] exp_a1, exp_a2, p2_add_next;
    logic [AW-1:0] srcs[$];
    logic [DW-1:0] rd1, rd2;
    op_t           e;
    #1;
    exp_ready = !reset && !pass2_exp;
    acc       = req_valid && exp_ready;
    srcs      = {};
    if (rs_en1) srcs.push_back(rs_add1);
    if (rs_en2) srcs.push_back(rs_add2);
    if (rs_en3) srcs.push_back(rs_add3);
    exp_ren1 = 1'b0; exp_ren2 = 1'b0; exp_a1 = '0; exp_a2 = '0;
    if (!reset && pass2_exp) begin
      exp_ren1 = 1'b1;
      exp_a1   = pass2_add;
    end else if (acc) begin
      if (srcs.size() > 0) begin exp_ren1 = 1'b1; exp_a1 = srcs[0]; end
      if (srcs.size() > 1) begin exp_ren2 = 1'b1; exp_a2 = srcs[1]; end
    end
    chk("req_ready", DW'(req_ready), DW'(exp_ready));
    chk("oc_pause",  DW'(oc_pause),  DW'(!reset && pass2_exp));
    chk("rf_ren1",   DW'(rf_ren1),   DW'(exp_ren1));
    chk("rf_ren2",   DW'(rf_ren2),   DW'(exp_ren2));
    chk("rf_radd1",  DW'(rf_radd1),  DW'(exp_a1));
    chk("rf_radd2",  DW'(rf_radd2),  DW'(exp_a2));

    // Register file: synchronous read returns contents from before this cycle's writes.
    rd1 = rf_ren1 ? mem[rf_radd1] : $urandom;
    rd2 = rf_ren2 ? mem[rf_radd2] : $urandom;
    if (wrd_en1) mem[wrd_add1] = wrd_data1;
    if (wrd_en2) mem[wrd_add2] = wrd_data2;

    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cap12 == cyc) begin
        q[i].v1 = q[i].en[0] ? mem[q[i].a1] : '0;
        q[i].v2 = q[i].en[1] ? mem[q[i].a2] : '0;
        if (q[i].en != 3'b111) q[i].v3 = q[i].en[2] ? mem[q[i].a3] : '0;
      end
      if (q[i].cap3 == cyc) q[i].v3 = mem[q[i].a3];
    end
    p2_next     = acc && (srcs.size() == 3);
    p2_add_next = rs_add3;
    if (acc) begin
      e.en    = {rs_en3, rs_en2, rs_en1};
      e.a1    = rs_add1; e.a2 = rs_add2; e.a3 = rs_add3;
      e.v1    = '0; e.v2 = '0; e.v3 = '0;
      e.cap12 = cyc + 1;
      e.cap3  = p2_next ? cyc + 2 : -1;
      e.due   = cyc + (p2_next ? 3 : 2);
      q.push_back(e);
    end
    if (reset) begin
      q.delete();
      pass2_exp = 1'b0;
      hold1 = '0; hold2 = '0; hold3 = '0;
    end else begin
      pass2_exp = p2_next;
      pass2_add = p2_add_next;
    end

    @(posedge clk);
    #1;
    cyc++;
    ov = (q.size() > 0) && (q[0].due == cyc);
    if (ov) begin
      hold1 = q[0].v1; hold2 = q[0].v2; hold3 = q[0].v3;
      void'(q.pop_front());
    end
    chk("op_valid", DW'(op_valid), DW'(ov));
    chk("op_data1", op_data1, hold1);
    chk("op_data2", op_data2, hold2);
    chk("op_data3", op_data3, hold3);
    @(negedge clk);
    rf_rdata1 = rd1;
    rf_rdata2 = rd2;
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_err = 0;
    pass2_exp = 1'b0; pass2_add = '0;
    hold1 = '0; hold2 = '0; hold3 = '0;
    rf_rdata1 = '0; rf_rdata2 = '0;
    rs_add1 = '0; rs_add2 = '0; rs_add3 = '0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[5] = 32'h11;
    mem[9] = 32'h22;
    idle();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;

    // Two sources, then an idle stretch.
    set_req(3'b011, 5, 9, 0); cycle();
    idle(); repeat (2) cycle();

    // Three sources; the held follow-on request is accepted once pass 2 ends.
    set_req(3'b111, 1, 2, 3); cycle();
    set_req(3'b011, 10, 11, 0); repeat (2) cycle();
    idle(); repeat (3) cycle();

    // Only source 3.
    set_req(3'b100, 0, 0, 7); cycle();
    idle(); repeat (2) cycle();

    // Forwarding: capture-cycle port-2 write wins, then issue-cycle port-1 write alone.
    set_req(3'b001, 4, 0, 0); set_wr(1'b1, 4, 32'hAA, 1'b0, 0, '0); cycle();
    idle(); set_wr(1'b0, 0, '0, 1'b1, 4, 32'hBB); cycle();
    idle(); repeat (2) cycle();
    set_req(3'b001, 4, 0, 0); set_wr(1'b1, 4, 32'hAA, 1'b0, 0, '0); cycle();
    idle(); repeat (3) cycle();

    // No sources.
    set_req(3'b000, 0, 0, 0); cycle();
    idle(); repeat (2) cycle();

    // Back-to-back two-source requests.
    for (int i = 0; i < 4; i++) begin
      set_req(3'b011, 20 + i, 30 + i, 0);
      cycle();
    end
    idle(); repeat (3) cycle();

    // Reset during pass 2 drops the request.
    set_req(3'b111, 1, 2, 3); cycle();
    idle(); reset = 1'b1; cycle();
    reset = 1'b0; repeat (4) cycle();

    // Randomized traffic over a small address range to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      {rs_en3, rs_en2, rs_en1} = 3'($urandom_range(0, 7));
      rs_add1 = AW'($urandom_range(0, 7));
      rs_add2 = AW'($urandom_range(0, 7));
      rs_add3 = AW'($urandom_range(0, 7));
      set_wr($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
             $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;
    idle(); repeat (4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
